// File: rtl/dp_controller_if.sv
// Bundle between the control FSM and its instruction memory / datapath.
// master = controller side, slave = memory/datapath side.
interface dp_controller_if #(
    parameter int M   = 3,
    parameter int N   = 8,
    parameter int PCW = 8
);
    logic [15:0]    instr;
    logic           imem_ack;
    logic           o_flag;
    logic           z_flag;
    logic           n_flag;
    logic [PCW-1:0] pc;
    logic           imem_req;
    logic [M-1:0]   waddr;
    logic [M-1:0]   ra;
    logic [M-1:0]   rb;
    logic [2:0]     op;
    logic           ie;
    logic           write;
    logic           reada;
    logic           readb;
    logic           en;
    logic           oe;
    logic [N-1:0]   offset;
    logic           bypassa;
    logic           bypassb;
    logic           dm_addr_le;
    logic           dm_we;
    logic           dm_re;
    logic           halted;

    modport master (
        input  instr, imem_ack, o_flag, z_flag, n_flag,
        output pc, imem_req, waddr, ra, rb, op, ie, write,
        output reada, readb, en, oe, offset, bypassa, bypassb,
        output dm_addr_le, dm_we, dm_re, halted
    );

    modport slave (
        output instr, imem_ack, o_flag, z_flag, n_flag,
        input  pc, imem_req, waddr, ra, rb, op, ie, write,
        input  reada, readb, en, oe, offset, bypassa, bypassb,
        input  dm_addr_le, dm_we, dm_re, halted
    );
endinterface

// File: rtl/dp_controller.sv
// Multi-cycle fetch/decode/execute controller for the 16-bit ISA,
// driving register-file/ALU datapath controls and a data-memory port.
module dp_controller #(
    parameter int M   = 3,
    parameter int N   = 8,
    parameter int PCW = 8
) (
    input  logic clk,
    input  logic rst,
    dp_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_MADDR,
        S_MLOAD, S_EXEC2, S_MSTORE, S_HALT
    } state_t;

    state_t         state, state_nx;
    logic [PCW-1:0] pc_q, pc_nx;
    logic [15:0]    ir;
    logic           sv_o, sv_z, sv_n;

    logic [3:0]        opc;
    logic [2:0]        rd, rs1, rs2;
    logic signed [7:0] simm;
    logic is_alu, is_nop, is_ld, is_st, is_ldi, is_hlt, is_br, is_mem;
    logic taken;

    assign opc  = ir[15:12];
    assign rd   = ir[11:9];
    assign rs1  = ir[8:6];
    assign rs2  = ir[5:3];
    assign simm = ir[7:0];

    assign is_nop = (opc == 4'b0111);
    assign is_alu = !opc[3] && !is_nop;
    assign is_ld  = (opc == 4'b1000);
    assign is_st  = (opc == 4'b1001);
    assign is_ldi = (opc == 4'b1010);
    assign is_hlt = (opc == 4'b1011);
    assign is_br  = (opc[3:2] == 2'b11);
    assign is_mem = is_ld || is_st;

    // Branches test the controller's saved flags, not the live datapath ones
    always_comb begin
        taken = 1'b0;
        unique case (opc[1:0])
            2'b00: taken = sv_z;
            2'b01: taken = sv_n;
            2'b10: taken = sv_o;
            2'b11: taken = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            pc_q  <= '0;
            ir    <= '0;
            sv_o  <= 1'b0;
            sv_z  <= 1'b0;
            sv_n  <= 1'b0;
        end else begin
            state <= state_nx;
            pc_q  <= pc_nx;
            if (state == S_FETCH && bus.imem_ack)
                ir <= bus.instr;
            if (state == S_WB && is_alu) begin
                sv_o <= bus.o_flag;
                sv_z <= bus.z_flag;
                sv_n <= bus.n_flag;
            end
        end
    end

    always_comb begin
        pc_nx = pc_q;
        if (state == S_DECODE) begin
            if (is_br && taken)
                pc_nx = pc_q + PCW'(simm);
            else
                pc_nx = pc_q + PCW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_FETCH:
                if (bus.imem_ack) state_nx = S_DECODE;
            S_DECODE:
                unique case (1'b1)
                    is_hlt:          state_nx = S_HALT;
                    is_br || is_nop: state_nx = S_FETCH;
                    default:         state_nx = S_EXEC;
                endcase
            S_EXEC:   state_nx = is_mem ? S_MADDR : S_WB;
            S_WB:     state_nx = S_FETCH;
            S_MADDR:  state_nx = is_ld ? S_MLOAD : S_EXEC2;
            S_MLOAD:  state_nx = S_FETCH;
            S_EXEC2:  state_nx = S_MSTORE;
            S_MSTORE: state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Outputs are forced quiet while rst is held so an abort never leaks a write
    always_comb begin
        bus.pc         = '0;
        bus.imem_req   = 1'b0;
        bus.waddr      = '0;
        bus.ra         = '0;
        bus.rb         = '0;
        bus.op         = 3'b000;
        bus.ie         = 1'b0;
        bus.write      = 1'b0;
        bus.reada      = 1'b0;
        bus.readb      = 1'b0;
        bus.en         = 1'b0;
        bus.oe         = 1'b0;
        bus.offset     = '0;
        bus.bypassa    = 1'b0;
        bus.bypassb    = 1'b0;
        bus.dm_addr_le = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_re      = 1'b0;
        bus.halted     = 1'b0;
        if (!rst) begin
            bus.pc = pc_q;
            unique case (state)
                S_FETCH: bus.imem_req = 1'b1;
                S_EXEC:
                    unique case (1'b1)
                        is_ldi: begin
                            bus.bypassa = 1'b1;
                            bus.offset  = N'(simm);
                            bus.op      = 3'b110;
                            bus.en      = 1'b1;
                        end
                        is_mem: begin
                            bus.ra    = M'(rs1);
                            bus.reada = 1'b1;
                            bus.op    = 3'b110;
                            bus.en    = 1'b1;
                        end
                        default: begin
                            bus.ra    = M'(rs1);
                            bus.rb    = M'(rs2);
                            bus.reada = 1'b1;
                            bus.readb = 1'b1;
                            bus.op    = opc[2:0];
                            bus.en    = 1'b1;
                        end
                    endcase
                S_WB: begin
                    bus.waddr = M'(rd);
                    bus.write = 1'b1;
                end
                S_MADDR: begin
                    bus.oe         = 1'b1;
                    bus.dm_addr_le = 1'b1;
                end
                S_MLOAD: begin
                    bus.dm_re = 1'b1;
                    bus.ie    = 1'b1;
                    bus.write = 1'b1;
                    bus.waddr = M'(rd);
                end
                S_EXEC2: begin
                    bus.ra    = M'(rs2);
                    bus.reada = 1'b1;
                    bus.op    = 3'b110;
                    bus.en    = 1'b1;
                end
                S_MSTORE: begin
                    bus.oe    = 1'b1;
                    bus.dm_we = 1'b1;
                end
                S_HALT: bus.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/dp_controller.md
Name: dp_controller

Overview:
- Multi-cycle control FSM that drives the register-file/ALU datapath's control inputs and consumes its o/z/n flags.
- Fetches 16-bit instructions from an instruction memory over a req/ack handshake and decodes them.
- Sequences read, ALU-register and write-back cycles, including loads/stores through an external data-memory port.
- Sits between instruction memory and the datapath; a top level wires it to both.

Parameters:
- M, 3, register address width (must be 3 for this ISA)
- N, 8, datapath width
- PCW, 8, program counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  16  instruction word from instruction memory
- imem_ack  in  1  instr valid this cycle
- o_flag, z_flag, n_flag  in  1 each  registered ALU flags from datapath
- pc  out  PCW  instruction address
- imem_req  out  1  fetch request
- waddr, ra, rb  out  M each  register addresses
- op  out  3  ALU opcode
- ie, write, reada, readb, en, oe  out  1 each  datapath controls
- offset  out  N  immediate to datapath
- bypassa, bypassb  out  1 each  datapath bypass selects (bypassb always 0)
- dm_addr_le  out  1  data memory latches address from datapath dout
- dm_we  out  1  data memory write of dout
- dm_re  out  1  data memory drives din this cycle
- halted  out  1  core stopped

Behaviour:
- Encoding: opc=[15:12], rd=[11:9], rs1=[8:6], rs2=[5:3], imm8=[7:0].
- ALU class (opc 0000-0110: ADD, SUB, AND, OR, XOR, NOT, MOV): op=opc[2:0]; MOV passes A.
- Other opcodes:
  - 0111 NOP; 1000 LD rd,[rs1]; 1001 ST [rs1],rs2; 1010 LDI rd,imm8; 1011 HLT.
  - 1100 BRZ, 1101 BRN, 1110 BRO, 1111 BRA; offset = sext(imm8).
- Defaults: every control output is 0 unless asserted by the current state.
- Reset: pc=0, IR=0, saved flags=0, halted=0, state=FETCH, all outputs 0. Reset in any state, including mid-instruction or mid-handshake, aborts and restarts at FETCH next cycle.
- FETCH:
  - imem_req=1, pc held.
  - Stay until imem_ack=1; on ack, IR<=instr and go to DECODE.
- DECODE:
  - pc<=pc+1 (wraps 2^PCW-1 -> 0).
  - ALU/LD/ST/LDI -> EXEC; NOP -> FETCH; HLT -> HALT.
  - Branch: if taken, pc<=pc+sext(imm8) (target relative to branch address, modulo 2^PCW), then FETCH.
  - Taken conditions: BRZ uses saved Z, BRN saved N, BRO saved O; BRA always taken.
- EXEC:
  - ALU: ra=rs1, rb=rs2, reada=readb=1, op, en=1.
  - LDI: bypassa=1, offset=imm8, op=110, en=1.
  - LD/ST phase 1: ra=rs1, reada=1, op=110, en=1.
  - ALU/LDI -> WB; LD/ST -> MADDR.
- WB:
  - waddr=rd, write=1, ie=0.
  - ALU class only: save o/z/n flags from inputs this cycle.
  - -> FETCH.
- MADDR: oe=1, dm_addr_le=1. LD -> MLOAD; ST -> EXEC2.
- MLOAD: dm_re=1, ie=1, write=1, waddr=rd -> FETCH.
- EXEC2: ra=rs2, reada=1, op=110, en=1 -> MSTORE.
- MSTORE: oe=1, dm_we=1 -> FETCH.
- HALT: halted=1, no outputs active, exit only by rst.
- Saved flags persist across LDI/LD/ST/branches (the datapath flags are clobbered; the controller keeps its own copy).
- Latency with zero-wait fetch (FETCH included):
  - ALU/LDI 4 cycles; LD 5; ST 6; branch/NOP 2.
  - Each extra wait cycle before imem_ack adds 1.
- Never assert write and dm_we together; oe=1 only in MADDR/MSTORE.

Test Plan:
- Reset, then fetch ADD r3,r1,r2 (0x0650) with ack in 1st cycle: exact per-state outputs are ra=1, rb=2, op=000, en=1; then waddr=3, write=1. pc=1; state back to FETCH after 4 cycles.
- Fetch wait: imem_ack held low 3 cycles -> imem_req stays 1, pc stable; IR loads only on ack cycle.
- LDI r5,0x7F (0xAA7F) then BRZ -2 (0xC0FE):
  - LDI gives bypassa=1, offset=0x7F, write waddr=5.
  - Saved Z still 0 -> branch not taken, pc=2.
- SUB r1,r1,r1 with z_flag=1 at WB, then LDI (saved flags kept), then BRZ +4 at pc=5 -> pc=9. BRA 0x80 at pc=0x10 -> pc=0x90. Branch at pc=0xFF not taken -> pc=0x00.
- LD r2,[r4] and ST [r4],r6:
  - Check dm_addr_le in MADDR and dm_re+ie+write waddr=2 in MLOAD.
  - ST: EXEC2 ra=6, dm_we=1 with oe=1; never write=1.
- HLT (0xB000): halted=1 and stays with acks present. rst asserted during EXEC of ADD -> next cycle FETCH, pc=0, no write pulse.
